serial_1101_tx: RTL and testbench
=================================

SERIAL_1101_TX -- requirements
Module: serial_1101_tx

Interface
REQ-001 Parameter GAP, default 2, number of forced-idle cycles after each frame (legal 0..15).
REQ-002 Parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  8  payload byte, sampled only on acceptance.
REQ-006 valid  input  1  producer requests transmission of data_in.
REQ-007 ready  output  1  block can accept a byte this cycle.
REQ-008 out  output  1  registered serial bit stream, one bit per clock.
REQ-009 busy  output  1  high while a frame bit is on out.
REQ-010 done  output  1  one-cycle pulse coincident with the parity bit on out.

Function
REQ-011 Frame SHALL be 13 bits, in order: preamble 1,1,0,1; data_in[7] down to data_in[0]; parity bit.
REQ-012 Parity bit SHALL be XOR of the 8 payload bits, inverted when PARITY_ODD=1.
REQ-013 Acceptance SHALL occur at a rising edge where valid=1, ready=1 and reset=0.
REQ-014 data_in SHALL be captured into an internal shift register at acceptance; later data_in changes SHALL NOT affect the frame.
REQ-015 First preamble bit SHALL appear on out in the cycle immediately after the acceptance edge; subsequent bits SHALL follow on consecutive cycles without gaps.
REQ-016 States SHALL be IDLE, PRE (4 cycles), DATA (8 cycles), PAR (1 cycle), GAP (GAP cycles; skipped when GAP=0).
REQ-017 Transitions: IDLE->PRE on acceptance; PRE->DATA after 4th bit; DATA->PAR after 8th bit; PAR->GAP (or ->IDLE when GAP=0); GAP->IDLE after GAP cycles.
REQ-018 ready SHALL be 1 only in IDLE; valid outside IDLE SHALL be ignored.
REQ-019 out SHALL be 0 in IDLE and GAP.
REQ-020 busy SHALL be 1 exactly during the 13 frame-bit cycles.
REQ-021 done SHALL be 1 only during the parity-bit cycle.
REQ-022 With valid held high, the next preamble SHALL start after exactly GAP+1 cycles of out=0 following the parity bit.
REQ-023 Bit and gap counters SHALL not wrap: each state exits exactly at its terminal count.

Reset
REQ-024 At a rising edge with reset=1: state IDLE, out=0, busy=0, done=0, ready=1 next cycle, shift register and counters cleared.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no remaining bits emitted; the aborted byte is discarded.
REQ-026 reset=1 together with valid=1 SHALL NOT cause acceptance; reset wins.

Verification
REQ-027 data_in=0xA5, PARITY_ODD=0, one valid pulse -> out = 1101 10100101 0, busy high 13 cycles, done on bit 13, then 2 zero cycles, ready=1.
REQ-028 data_in=0x01, PARITY_ODD=0 -> parity bit 1; rerun with PARITY_ODD=1 -> parity bit 0.
REQ-029 valid held high, data_in=0xFF then 0x00, GAP=2 -> frame 1101 11111111 0, exactly 3 zero cycles, frame 1101 00000000 0.
REQ-030 Accept 0x3C, change data_in to 0xC3 the next cycle -> transmitted payload 00111100.
REQ-031 Assert reset for one cycle during the 3rd payload bit -> out=0, busy=0 from the next cycle, ready=1, no done pulse; a new 0x5A then transmits correctly.
REQ-032 GAP=0, valid held high -> exactly one zero cycle between the parity bit and the next preamble bit.

Source files
------------

// File: rtl/serial_1101_tx.sv
// rtl/serial_1101_tx.sv - serial framer: preamble 1101, MSB-first payload byte, parity bit, forced idle gap
// One frame bit per clock; a byte is accepted only in IDLE and is emitted starting the very next cycle.
module serial_1101_tx #(
   parameter int unsigned GAP        = 2,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_PAR,
      S_GAP
   } state_t;

   localparam logic [3:0] PREAMBLE = 4'b1101;
   localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
   localparam bit         HAS_GAP  = (GAP != 0);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [11:0] shreg, shreg_n;
   logic        out_n, busy_n, done_n;
   logic        par_bit;

   assign par_bit = (^data_in) ^ PARITY_ODD;
   assign ready   = (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         shreg <= 12'd0;
         out   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shreg <= shreg_n;
         out   <= out_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // shreg holds the frame bits still to come after the one currently on out
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      out_n   = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (valid) begin
               state_n = S_PRE;
               cnt_n   = 4'd0;
               shreg_n = {PREAMBLE[2:0], data_in, par_bit};
               out_n   = PREAMBLE[3];
               busy_n  = 1'b1;
            end
         end
         S_PRE: begin
            out_n   = shreg[11];
            shreg_n = {shreg[10:0], 1'b0};
            busy_n  = 1'b1;
            if (cnt == 4'd3) begin
               state_n = S_DATA;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_DATA: begin
            out_n   = shreg[11];
            shreg_n = {shreg[10:0], 1'b0};
            busy_n  = 1'b1;
            if (cnt == 4'd7) begin
               state_n = S_PAR;
               cnt_n   = 4'd0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         S_PAR: begin
            cnt_n   = 4'd0;
            shreg_n = 12'd0;
            state_n = HAS_GAP ? S_GAP : S_IDLE;
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = S_IDLE;
               cnt_n   = 4'd0;
            end else begin
               cnt_n = cnt + 4'd1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_1101_tx.sv
// tb/tb_serial_1101_tx.sv - scoreboard bench for serial_1101_tx (GAP=2 even, GAP=2 odd, GAP=0 even)
// Stimulus queues hand-computed frames at acceptance; a negedge monitor pops and compares each frame.
module tb_serial_1101_tx;

   typedef struct {
      logic [12:0] f_even;
      logic [12:0] f_odd;
      bit          chk;
      int          gap;
   } item_t;

   logic       clk;
   logic       reset;
   logic [7:0] data_in, data_in2;
   logic       valid, valid2;
   logic       ready0, out0, busy0, done0;
   logic       ready1, out1, busy1, done1;
   logic       ready2, out2, busy2, done2;

   item_t q0[$];
   item_t q1[$];
   item_t q2[$];

   int checks = 0;
   int errors = 0;

   serial_1101_tx #(.GAP(2), .PARITY_ODD(1'b0)) u0 (
      .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
      .ready(ready0), .out(out0), .busy(busy0), .done(done0));

   serial_1101_tx #(.GAP(2), .PARITY_ODD(1'b1)) u1 (
      .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
      .ready(ready1), .out(out1), .busy(busy1), .done(done1));

   serial_1101_tx #(.GAP(0), .PARITY_ODD(1'b0)) u2 (
      .clk(clk), .reset(reset), .data_in(data_in2), .valid(valid2),
      .ready(ready2), .out(out2), .busy(busy2), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // monitor state, one slot per DUT
   int          pos[3]  = '{0, 0, 0};
   int          idle[3] = '{1000, 1000, 1000};
   logic [12:0] got[3];
   logic [12:0] dm[3];
   logic [12:0] expf[3];
   bit          rst_prev = 1'b1;

   always @(negedge clk) begin
      logic  b, o, d, r;
      int    gapk;
      item_t it;
      bit    have;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin b = busy0; o = out0; d = done0; r = ready0; end
            1:       begin b = busy1; o = out1; d = done1; r = ready1; end
            default: begin b = busy2; o = out2; d = done2; r = ready2; end
         endcase
         gapk = (k == 2) ? 0 : 2;
         if (rst_prev) begin
            check("reset_state", k, {28'd0, b, o, d, r}, 4'b0001);
            pos[k]  = 0;
            idle[k] = 1000;
         end else if (b) begin
            check("ready_busy", k, int'(r), 0);
            if (pos[k] == 0) begin
               have = 1'b0;
               if (k == 0 && q0.size() != 0) begin it = q0.pop_front(); have = 1'b1; end
               if (k == 1 && q1.size() != 0) begin it = q1.pop_front(); have = 1'b1; end
               if (k == 2 && q2.size() != 0) begin it = q2.pop_front(); have = 1'b1; end
               check("frame_expected", k, int'(have), 1);
               if (have) begin
                  expf[k] = (k == 1) ? it.f_odd : it.f_even;
                  if (it.chk) check("gap_zero_cycles", k, idle[k], it.gap);
               end else begin
                  expf[k] = 13'd0;
               end
               got[k] = 13'd0;
               dm[k]  = 13'd0;
            end
            got[k] = {got[k][11:0], o};
            dm[k]  = {dm[k][11:0], d};
            pos[k] = pos[k] + 1;
            if (pos[k] == 13) begin
               check("frame_bits", k, int'(got[k]), int'(expf[k]));
               check("done_pulse", k, int'(dm[k]), 1);
               pos[k]  = 0;
               idle[k] = 0;
            end
         end else begin
            if (pos[k] != 0) begin
               check("frame_truncated", k, pos[k], 0);
               pos[k] = 0;
            end
            if (idle[k] < 1000) idle[k] = idle[k] + 1;
            check("idle_out_done", k, {30'd0, o, d}, 0);
            check("ready_idle", k, int'(r), int'(idle[k] > gapk));
         end
      end
      rst_prev = reset;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // leaves valid high on return so callers can chain back-to-back frames
   task automatic send(input int ch, input logic [7:0] b, input logic [12:0] fe,
                       input logic [12:0] fo, input bit chk, input int gap);
      bit r, rs, ok;
      item_t it;
      it.f_even = fe;
      it.f_odd  = fo;
      it.chk    = chk;
      it.gap    = gap;
      ok = 1'b0;
      if (ch == 0) begin data_in = b; valid = 1'b1; end
      else begin data_in2 = b; valid2 = 1'b1; end
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         r  = (ch == 0) ? ready0 : ready2;
         rs = reset;
         @(posedge clk);
         #1;
         if (r && !rs) begin
            ok = 1'b1;
            if (ch == 0) begin q0.push_back(it); q1.push_back(it); end
            else q2.push_back(it);
         end
      end
      check("accept_timeout", ch, int'(ok), 1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
             !busy0 && !busy1 && !busy2 && pos[0] == 0 && pos[1] == 0 && pos[2] == 0)
            ok = 1'b1;
      end
      check("drain_timeout", 0, int'(ok), 1);
      repeat (5) tick();
   endtask

   initial begin
      reset    = 1'b1;
      valid    = 1'b1;
      data_in  = 8'h33;
      valid2   = 1'b1;
      data_in2 = 8'h33;
      repeat (3) tick();
      reset  = 1'b0;
      valid  = 1'b0;
      valid2 = 1'b0;
      repeat (3) tick();

      send(0, 8'hA5, 13'b1101_10100101_0, 13'b1101_10100101_1, 1'b0, 0);
      valid = 1'b0;
      drain();

      send(0, 8'h01, 13'b1101_00000001_1, 13'b1101_00000001_0, 1'b0, 0);
      valid = 1'b0;
      drain();

      send(0, 8'hFF, 13'b1101_11111111_0, 13'b1101_11111111_1, 1'b0, 0);
      send(0, 8'h00, 13'b1101_00000000_0, 13'b1101_00000000_1, 1'b1, 3);
      valid = 1'b0;
      drain();

      send(0, 8'h3C, 13'b1101_00111100_0, 13'b1101_00111100_1, 1'b0, 0);
      data_in = 8'hC3;
      valid   = 1'b0;
      drain();

      // abort while the third payload bit is on out; valid during reset must be ignored
      send(0, 8'hE7, 13'b1101_11100111_0, 13'b1101_11100111_1, 1'b0, 0);
      valid = 1'b0;
      repeat (6) tick();
      reset   = 1'b1;
      valid   = 1'b1;
      data_in = 8'h5A;
      tick();
      reset = 1'b0;
      send(0, 8'h5A, 13'b1101_01011010_0, 13'b1101_01011010_1, 1'b0, 0);
      valid = 1'b0;
      drain();

      send(2, 8'h81, 13'b1101_10000001_0, 13'b1101_10000001_1, 1'b0, 0);
      send(2, 8'h7E, 13'b1101_01111110_0, 13'b1101_01111110_1, 1'b1, 1);
      send(2, 8'h01, 13'b1101_00000001_1, 13'b1101_00000001_0, 1'b1, 1);
      valid2 = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
